// File: rtl/br_update_scheduler_if.sv
// ---------------------------------------------------------------------------
// br_update_scheduler_if
// Bundles the ROB-side request handshake and the predictor-side update bus
// of the branch update scheduler.
//   req_valid_i / req_idx_i / req_taken_i : resolved branch offered by the ROB
//   req_ready_o                           : scheduler can accept this cycle
//   upd_valid_o / upd_idx_o / upd_taken_o / upd_clear_o : BHT update port
// Modports: master = ROB/predictor side, slave = scheduler.
// ---------------------------------------------------------------------------
interface br_update_scheduler_if #(
  parameter int IDX_WIDTH = 8
) ();
  logic                 req_valid_i;
  logic [IDX_WIDTH-1:0] req_idx_i;
  logic                 req_taken_i;
  logic                 req_ready_o;
  logic                 upd_valid_o;
  logic [IDX_WIDTH-1:0] upd_idx_o;
  logic                 upd_taken_o;
  logic                 upd_clear_o;

  modport master (
    output req_valid_i, req_idx_i, req_taken_i,
    input  req_ready_o, upd_valid_o, upd_idx_o, upd_taken_o, upd_clear_o
  );

  modport slave (
    input  req_valid_i, req_idx_i, req_taken_i,
    output req_ready_o, upd_valid_o, upd_idx_o, upd_taken_o, upd_clear_o
  );
endinterface

// File: rtl/br_update_scheduler.sv
// ---------------------------------------------------------------------------
// br_update_scheduler
// Buffers branch-outcome updates from the ROB commit bus in a small FIFO and
// issues them, one per cycle, to the BHT's single update port. On a clear
// request it drains the FIFO, then sweeps every BHT index with a clear strobe.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rdy             global ready; 0 freezes all state and holds outputs
//   bus (slave)     request handshake + update bus (br_update_scheduler_if)
//   clear_req_i     one-cycle pulse requesting a full-table clear
//   clear_busy_o    drain/sweep in progress
//   stat_taken_o    taken updates issued (BR_UPD_STATS_EN)
//   stat_ntaken_o   not-taken updates issued (BR_UPD_STATS_EN)
// Optional feature: define BR_UPD_STATS_EN to build the saturating
// statistics counters; otherwise both stat ports are tied to 0.
// ---------------------------------------------------------------------------
module br_update_scheduler #(
  parameter int IDX_WIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  br_update_scheduler_if.slave bus,
  input  logic                 clear_req_i,
  output logic                 clear_busy_o,
  output logic [CNT_WIDTH-1:0] stat_taken_o,
  output logic [CNT_WIDTH-1:0] stat_ntaken_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWEEP = 2'd2
  } state_e;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [AW:0]          wr_ptr_r;
  logic [AW:0]          rd_ptr_r;
  logic [IDX_WIDTH-1:0] mem_idx_r [DEPTH];
  logic                 mem_taken_r [DEPTH];
  logic [IDX_WIDTH:0]   sweep_cnt_r;
  logic                 upd_valid_r;
  logic [IDX_WIDTH-1:0] upd_idx_r;
  logic                 upd_taken_r;
  logic                 upd_clear_r;

  logic                 full_s;
  logic                 empty_s;
  logic                 ready_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 enter_sweep_s;
  logic                 sweep_strobe_s;
  logic [IDX_WIDTH-1:0] head_idx_s;
  logic                 head_taken_s;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);

  // Ready depends on registered state only, never on a same-cycle pop.
  assign ready_s        = (state_r == ST_IDLE) && !full_s;
  assign push_s         = rdy && bus.req_valid_i && ready_s;
  assign pop_s          = rdy && !empty_s && ((state_r == ST_IDLE) || (state_r == ST_DRAIN));
  assign enter_sweep_s  = rdy && (state_r == ST_DRAIN) && empty_s;
  // Sweep counter MSB set means the last index has already been driven.
  assign sweep_strobe_s = rdy && (state_r == ST_SWEEP) && !sweep_cnt_r[IDX_WIDTH];
  assign head_idx_s     = mem_idx_r[rd_ptr_r[AW-1:0]];
  assign head_taken_s   = mem_taken_r[rd_ptr_r[AW-1:0]];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; every transition is qualified by rdy.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rdy && clear_req_i) state_nxt_s = ST_DRAIN;
        else                    state_nxt_s = ST_IDLE;
      end
      ST_DRAIN: begin
        if (enter_sweep_s) state_nxt_s = ST_SWEEP;
        else               state_nxt_s = ST_DRAIN;
      end
      ST_SWEEP: begin
        if (rdy && sweep_cnt_r[IDX_WIDTH]) state_nxt_s = ST_IDLE;
        else                               state_nxt_s = ST_SWEEP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FIFO read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_idx_r[i]   <= {IDX_WIDTH{1'b0}};
        mem_taken_r[i] <= 1'b0;
      end
    end else if (push_s) begin
      mem_idx_r[wr_ptr_r[AW-1:0]]   <= bus.req_idx_i;
      mem_taken_r[wr_ptr_r[AW-1:0]] <= bus.req_taken_i;
    end
  end

  // Sweep index counter: cleared on entry to SWEEP, advanced per clear strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt_r <= {(IDX_WIDTH+1){1'b0}};
    end else if (enter_sweep_s) begin
      sweep_cnt_r <= {(IDX_WIDTH+1){1'b0}};
    end else if (sweep_strobe_s) begin
      sweep_cnt_r <= sweep_cnt_r + {{IDX_WIDTH{1'b0}}, 1'b1};
    end
  end

  // Update output register: FIFO head, sweep clear strobe, or idle; held when rdy=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid_r <= 1'b0;
      upd_idx_r   <= {IDX_WIDTH{1'b0}};
      upd_taken_r <= 1'b0;
      upd_clear_r <= 1'b0;
    end else if (rdy) begin
      if (pop_s) begin
        upd_valid_r <= 1'b1;
        upd_idx_r   <= head_idx_s;
        upd_taken_r <= head_taken_s;
        upd_clear_r <= 1'b0;
      end else if (sweep_strobe_s) begin
        upd_valid_r <= 1'b1;
        upd_idx_r   <= sweep_cnt_r[IDX_WIDTH-1:0];
        upd_taken_r <= 1'b0;
        upd_clear_r <= 1'b1;
      end else begin
        upd_valid_r <= 1'b0;
        upd_taken_r <= 1'b0;
        upd_clear_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready_o = ready_s;
  assign bus.upd_valid_o = upd_valid_r;
  assign bus.upd_idx_o   = upd_idx_r;
  assign bus.upd_taken_o = upd_taken_r;
  assign bus.upd_clear_o = upd_clear_r;
  assign clear_busy_o    = (state_r != ST_IDLE);

`ifdef BR_UPD_STATS_EN
  logic [CNT_WIDTH-1:0] stat_taken_r;
  logic [CNT_WIDTH-1:0] stat_ntaken_r;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    else    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Saturating per-direction counters of issued non-clear updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken_r  <= {CNT_WIDTH{1'b0}};
      stat_ntaken_r <= {CNT_WIDTH{1'b0}};
    end else if (enter_sweep_s) begin
      stat_taken_r  <= {CNT_WIDTH{1'b0}};
      stat_ntaken_r <= {CNT_WIDTH{1'b0}};
    end else if (pop_s) begin
      if (head_taken_s) stat_taken_r  <= sat_inc(stat_taken_r);
      else              stat_ntaken_r <= sat_inc(stat_ntaken_r);
    end
  end

  assign stat_taken_o  = stat_taken_r;
  assign stat_ntaken_o = stat_ntaken_r;
`else
  assign stat_taken_o  = {CNT_WIDTH{1'b0}};
  assign stat_ntaken_o = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_br_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_br_update_scheduler
// Self-checking bench: a transaction-level reference model (queue of pending
// updates, drain/sweep phase, expected strobe) is checked on every cycle,
// plus a vector table for basic issue/back-pressure timing and directed
// sequences for drain+sweep, mid-sweep reset, statistics and random traffic.
// ---------------------------------------------------------------------------
module tb_br_update_scheduler;
  localparam int IW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
`ifdef BR_UPD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rdy = 1'b0;
  logic          clear_req = 1'b0;
  logic          clear_busy;
  logic [CW-1:0] st_t;
  logic [CW-1:0] st_n;

  br_update_scheduler_if #(.IDX_WIDTH(IW)) bus ();

  br_update_scheduler #(.IDX_WIDTH(IW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rdy           (rdy),
    .bus           (bus),
    .clear_req_i   (clear_req),
    .clear_busy_o  (clear_busy),
    .stat_taken_o  (st_t),
    .stat_ntaken_o (st_n)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [IW-1:0] idx;
    logic          taken;
  } req_t;

  req_t          q[$];
  int            mode;     // 0 idle, 1 drain, 2 sweep
  int            sweep_i;
  logic          e_vld, e_tkn, e_clr;
  logic [IW-1:0] e_idx;
  int            e_st_t, e_st_n;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic model_reset();
    q.delete();
    mode = 0; sweep_i = 0;
    e_vld = 1'b0; e_tkn = 1'b0; e_clr = 1'b0; e_idx = '0;
    e_st_t = 0; e_st_n = 0;
  endtask

  // Evaluate the rules for the coming clock edge using the current inputs.
  task automatic model_step();
    bit   acc;
    int   old_mode;
    req_t h;
    if (rdy) begin
      old_mode = mode;
      acc = bus.req_valid_i && (mode == 0) && (q.size() < DEPTH);
      e_vld = 1'b0; e_tkn = 1'b0; e_clr = 1'b0;
      if (mode != 2 && q.size() > 0) begin
        h = q.pop_front();
        e_vld = 1'b1; e_idx = h.idx; e_tkn = h.taken;
        if (STATS && h.taken && e_st_t < (1 << CW) - 1) e_st_t++;
        if (STATS && !h.taken && e_st_n < (1 << CW) - 1) e_st_n++;
      end else if (mode == 1) begin
        mode = 2; sweep_i = 0; e_st_t = 0; e_st_n = 0;
      end else if (mode == 2) begin
        if (sweep_i < (1 << IW)) begin
          e_vld = 1'b1; e_clr = 1'b1; e_idx = sweep_i[IW-1:0]; sweep_i++;
        end else begin
          mode = 0;
        end
      end
      if (old_mode == 0 && clear_req) mode = 1;
      if (acc) q.push_back({bus.req_idx_i, bus.req_taken_i});
    end
  endtask

  task automatic check(string name);
    bit e_rdy, e_busy, ok;
    e_rdy  = (mode == 0) && (q.size() < DEPTH);
    e_busy = (mode != 0);
    ok = (bus.upd_valid_o === e_vld) && (!e_vld || bus.upd_idx_o === e_idx) &&
         (bus.upd_taken_o === e_tkn) && (bus.upd_clear_o === e_clr) &&
         (bus.req_ready_o === e_rdy) && (clear_busy === e_busy) &&
         (st_t === e_st_t[CW-1:0]) && (st_n === e_st_n[CW-1:0]);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s t=%0t: got vld=%b idx=%h tkn=%b clr=%b rdy=%b busy=%b st=%0d/%0d, want vld=%b idx=%h tkn=%b clr=%b rdy=%b busy=%b st=%0d/%0d",
               name, $time, bus.upd_valid_o, bus.upd_idx_o, bus.upd_taken_o, bus.upd_clear_o,
               bus.req_ready_o, clear_busy, st_t, st_n, e_vld, e_idx, e_tkn, e_clr, e_rdy, e_busy,
               e_st_t, e_st_n);
    end
  endtask

  task automatic chk(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic step(string name);
    model_step();
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic set_in(bit r, bit v, logic [IW-1:0] idx, bit t, bit c);
    rdy = r; bus.req_valid_i = v; bus.req_idx_i = idx; bus.req_taken_i = t; clear_req = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();
    #2;
    check("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Run idle cycles until the clear sequence ends, tracking sweep strobes.
  task automatic run_sweep(output int n_clr, output int order_err, output int rdy_hi);
    int nxt;
    nxt = 0; n_clr = 0; order_err = 0; rdy_hi = 0;
    set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if (!clear_busy) break;
      step("sweep");
      if (bus.upd_valid_o && bus.upd_clear_o) begin
        if (bus.upd_idx_o != nxt[IW-1:0]) order_err++;
        nxt++;
        n_clr++;
      end
      if (bus.req_ready_o && clear_busy) rdy_hi++;
    end
    chk("sweep_terminates", int'(clear_busy), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            r, v;
    logic [IW-1:0] idx;
    bit            t;
    bit            ev;
    logic [IW-1:0] ei;
    bit            et, er;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, logic [IW-1:0] idx, bit t,
                              bit ev, logic [IW-1:0] ei, bit et, bit er);
    vec_t x;
    x.r = r; x.v = v; x.idx = idx; x.t = t; x.ev = ev; x.ei = ei; x.et = et; x.er = er;
    return x;
  endfunction

  vec_t vecs[22];

  initial begin
    int n_clr, order_err, rdy_hi, found;

    // single request, back-to-back burst, alternating rdy
    vecs[0]  = mk(1, 1, 8'h12, 1, 0, 8'h00, 0, 1);
    vecs[1]  = mk(1, 0, 8'h00, 0, 1, 8'h12, 1, 1);
    vecs[2]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    vecs[3]  = mk(1, 1, 8'h01, 1, 0, 8'h00, 0, 1);
    vecs[4]  = mk(1, 1, 8'h02, 0, 1, 8'h01, 1, 1);
    vecs[5]  = mk(1, 1, 8'h03, 1, 1, 8'h02, 0, 1);
    vecs[6]  = mk(1, 1, 8'h04, 0, 1, 8'h03, 1, 1);
    vecs[7]  = mk(1, 1, 8'h05, 1, 1, 8'h04, 0, 1);
    vecs[8]  = mk(1, 1, 8'h06, 0, 1, 8'h05, 1, 1);
    vecs[9]  = mk(1, 0, 8'h00, 0, 1, 8'h06, 0, 1);
    vecs[10] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    vecs[11] = mk(1, 1, 8'h01, 1, 0, 8'h00, 0, 1);
    vecs[12] = mk(0, 1, 8'h02, 0, 0, 8'h00, 0, 1);
    vecs[13] = mk(1, 1, 8'h02, 0, 1, 8'h01, 1, 1);
    vecs[14] = mk(0, 1, 8'h03, 1, 1, 8'h01, 1, 1);
    vecs[15] = mk(1, 1, 8'h03, 1, 1, 8'h02, 0, 1);
    vecs[16] = mk(0, 1, 8'h04, 0, 1, 8'h02, 0, 1);
    vecs[17] = mk(1, 1, 8'h04, 0, 1, 8'h03, 1, 1);
    vecs[18] = mk(0, 0, 8'h00, 0, 1, 8'h03, 1, 1);
    vecs[19] = mk(1, 0, 8'h00, 0, 1, 8'h04, 0, 1);
    vecs[20] = mk(0, 0, 8'h00, 0, 1, 8'h04, 0, 1);
    vecs[21] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);

    do_reset();

    for (int i = 0; i < 22; i++) begin
      set_in(vecs[i].r, vecs[i].v, vecs[i].idx, vecs[i].t, 1'b0);
      step("vec_model");
      n_checks++;
      if (bus.upd_valid_o !== vecs[i].ev || bus.req_ready_o !== vecs[i].er ||
          (vecs[i].ev && (bus.upd_idx_o !== vecs[i].ei || bus.upd_taken_o !== vecs[i].et))) begin
        n_fail++;
        $display("FAIL vec[%0d]: got vld=%b idx=%h tkn=%b rdy=%b want vld=%b idx=%h tkn=%b rdy=%b",
                 i, bus.upd_valid_o, bus.upd_idx_o, bus.upd_taken_o, bus.req_ready_o,
                 vecs[i].ev, vecs[i].ei, vecs[i].et, vecs[i].er);
      end
    end

    // drain two queued updates, then a full clear sweep
    set_in(1'b1, 1'b1, 8'hA1, 1'b1, 1'b0);
    step("drain_push1");
    set_in(1'b1, 1'b1, 8'hA2, 1'b0, 1'b1);
    step("drain_push2_clear");
    chk("drain_busy", int'(clear_busy), 1);
    chk("drain_ready_low", int'(bus.req_ready_o), 0);
    run_sweep(n_clr, order_err, rdy_hi);
    chk("sweep_count", n_clr, 1 << IW);
    chk("sweep_order", order_err, 0);
    chk("sweep_ready_low", rdy_hi, 0);
    chk("sweep_end_ready", int'(bus.req_ready_o), 1);

    // asynchronous reset in the middle of a sweep
    set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step("sweep2_clear");
    set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      step("sweep2");
      if (bus.upd_valid_o && bus.upd_clear_o && bus.upd_idx_o == 8'h40) begin
        found = 1;
        break;
      end
    end
    chk("sweep_reach_40", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(bus.upd_valid_o), 0);
    chk("async_rst_clear", int'(bus.upd_clear_o), 0);
    chk("async_rst_busy", int'(clear_busy), 0);
    do_reset();
    set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("post_reset_idle");
    chk("post_reset_ready", int'(bus.req_ready_o), 1);

    // statistics: 20 taken + 3 not-taken, then a clear sweep
    for (int i = 0; i < 23; i++) begin
      set_in(1'b1, 1'b1, i[IW-1:0], (i % 8) != 3, 1'b0);
      step("stats_push");
    end
    set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("stats_idle1");
    step("stats_idle2");
    chk("stat_taken", int'(st_t), STATS ? 15 : 0);
    chk("stat_ntaken", int'(st_n), STATS ? 3 : 0);
    set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step("stats_clear");
    run_sweep(n_clr, order_err, rdy_hi);
    chk("stat_taken_cleared", int'(st_t), 0);
    chk("stat_ntaken_cleared", int'(st_n), 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom % 4) != 0, ($urandom % 3) != 0, IW'($urandom),
             $urandom % 2, ($urandom % 250) == 0);
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
